// File: rtl/iis_pkg.sv
// rtl/iis_pkg.sv - shared types and constants for the I2S receive front-end
package iis_pkg;

  // Deserialiser states: hunting for word alignment, then alternating channels.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

  // Default channel word width used by the frame type.
  localparam int unsigned IIS_DATA_W = 16;

  // Word-select levels of the two channels.
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // One stereo frame as it leaves the FIFO: left word in the upper half.
  typedef struct packed {
    logic [IIS_DATA_W-1:0] left;
    logic [IIS_DATA_W-1:0] right;
  } iis_frame_t;

endpackage

// File: rtl/iis_rx_fifo.sv
// rtl/iis_rx_fifo.sv - synchronous first-word-fall-through FIFO with drop flag
module iis_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_drop;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still
  // lands when the head is being taken.
  assign w_pop   = pop_i & ~flush_i & ~w_empty;
  assign w_push  = push_i & ~flush_i & (~w_full | w_pop);

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointers, occupancy and the registered drop pulse.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      r_drop  <= push_i & w_full & ~w_pop;
    end
  end

  assign pop_data_o = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty_o    = w_empty;
  assign level_o    = r_level;
  assign drop_o     = r_drop;

endmodule

// File: rtl/iis_rx_deser.sv
// rtl/iis_rx_deser.sv - I2S pin synchroniser, stereo deserialiser and frame buffer
module iis_rx_deser
  import iis_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic                          sck_i,
  input  logic                          ws_i,
  input  logic                          sd_i,
  output logic [2*DATA_W-1:0]           frame_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        r_sck_sync;
  logic [1:0]        r_ws_sync;
  logic [1:0]        r_sd_sync;
  logic              r_sck_q;

  rx_state_e         r_state;
  rx_state_e         w_state_nx;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_left;
  logic              r_ws_prev;

  logic              w_sck_s;
  logic              w_ws_s;
  logic              w_sd_s;
  logic              w_rise;
  logic              w_cnt_full;
  logic [DATA_W-1:0] w_shift_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [DATA_W-1:0] w_word;
  logic              w_clear;
  logic              w_shift_en;
  logic              w_latch_left;
  logic              w_push;
  logic              w_empty;

  // Two-flop synchronisers on the pins plus a delay flop for SCK edge detect;
  // these keep running while the receiver is disabled.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
      r_sck_q    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[0], sck_i};
      r_ws_sync  <= {r_ws_sync[0], ws_i};
      r_sd_sync  <= {r_sd_sync[0], sd_i};
      r_sck_q    <= r_sck_sync[1];
    end
  end

  assign w_sck_s = r_sck_sync[1];
  assign w_ws_s  = r_ws_sync[1];
  assign w_sd_s  = r_sd_sync[1];
  assign w_rise  = w_sck_s & ~r_sck_q;

  // Bits past DATA_W are ignored: the shifter freezes once the count saturates.
  assign w_cnt_full = (r_cnt == CNT_W'(DATA_W));
  assign w_shift_nx = w_cnt_full ? r_shift : {r_shift[DATA_W-2:0], w_sd_s};
  assign w_cnt_nx   = w_cnt_full ? r_cnt : r_cnt + 1'b1;
  // Short words are left-aligned so the MSB always sits at the top.
  assign w_word     = w_shift_nx << (CNT_W'(DATA_W) - w_cnt_nx);

  // State register of the channel tracker.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and per-edge actions; the bit seen with the new WS level is
  // still the last bit of the channel that is ending.
  always_comb begin
    w_state_nx   = r_state;
    w_clear      = 1'b0;
    w_shift_en   = 1'b0;
    w_latch_left = 1'b0;
    w_push       = 1'b0;
    if (en_i && w_rise) begin
      case (r_state)
        SYNC: begin
          if (r_ws_prev == WS_RIGHT && w_ws_s == WS_LEFT) begin
            w_state_nx = LEFT;
            w_clear    = 1'b1;
          end
        end
        LEFT: begin
          if (w_ws_s == WS_RIGHT) begin
            w_latch_left = 1'b1;
            w_clear      = 1'b1;
            w_state_nx   = RIGHT;
          end else begin
            w_shift_en = 1'b1;
          end
        end
        RIGHT: begin
          if (w_ws_s == WS_LEFT) begin
            w_push     = 1'b1;
            w_clear    = 1'b1;
            w_state_nx = LEFT;
          end else begin
            w_shift_en = 1'b1;
          end
        end
        default: begin
          w_state_nx = SYNC;
        end
      endcase
    end
    if (!en_i) begin
      w_state_nx = SYNC;
    end
  end

  // Shifter, bit counter, held left word and previous WS sample.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_left    <= '0;
      r_ws_prev <= 1'b0;
    end else if (!en_i) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_left    <= '0;
      r_ws_prev <= 1'b0;
    end else begin
      if (w_rise) begin
        r_ws_prev <= w_ws_s;
      end
      if (w_clear) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_shift_en) begin
        r_shift <= w_shift_nx;
        r_cnt   <= w_cnt_nx;
      end
      if (w_latch_left) begin
        r_left <= w_word;
      end
    end
  end

  iis_rx_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .flush_i     (~en_i),
    .push_i      (w_push),
    .push_data_i ({r_left, w_word}),
    .pop_i       (ready_i),
    .pop_data_o  (frame_o),
    .empty_o     (w_empty),
    .level_o     (level_o),
    .drop_o      (overrun_o)
  );

  assign valid_o = ~w_empty;

endmodule

// File: tb/tb_iis_rx_deser.sv
// tb/tb_iis_rx_deser.sv - randomized self-checking bench for iis_rx_deser
module tb_iis_rx_deser;

  localparam int DW  = 16;
  localparam int DEP = 4;

  logic            clk_i = 1'b0;
  logic            rst_n = 1'b0;
  logic            en_i = 1'b0;
  logic            sck_i = 1'b0;
  logic            ws_i = 1'b0;
  logic            sd_i = 1'b0;
  logic            ready_i = 1'b0;
  logic [2*DW-1:0] frame_o;
  logic            valid_o;
  logic [2:0]      level_o;
  logic            overrun_o;

  int n_total = 0;
  int n_bad = 0;
  int ovr_seen = 0;
  int ovr_exp = 0;
  logic [31:0] exp_q[$];

  iis_rx_deser #(.DATA_W(DW), .FIFO_DEPTH(DEP)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .en_i      (en_i),
    .sck_i     (sck_i),
    .ws_i      (ws_i),
    .sd_i      (sd_i),
    .frame_o   (frame_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .level_o   (level_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (overrun_o) ovr_seen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] align_w(input logic [31:0] w, input int n);
    if (n >= DW) return DW'(w >> (n - DW));
    else return DW'(w << (DW - n));
  endfunction

  // One SCK period: pins change with the falling edge, sampled on the rising.
  task automatic send_bit(input logic ws, input logic sd);
    sck_i = 1'b0;
    ws_i = ws;
    sd_i = sd;
    repeat ($urandom_range(2, 3)) @(negedge clk_i);
    sck_i = 1'b1;
    repeat ($urandom_range(2, 3)) @(negedge clk_i);
  endtask

  task automatic preamble();
    send_bit(1'b1, 1'($urandom));
    send_bit(1'b1, 1'($urandom));
    send_bit(1'b0, 1'($urandom));
  endtask

  // Left word: WS low except its last bit; right word: WS high except its last bit.
  task automatic send_frame(input logic [31:0] l, input int nl,
                            input logic [31:0] r, input int nr, input bit pop_at_push);
    logic [31:0] f;
    for (int i = nl - 1; i >= 0; i--) send_bit(i == 0, l[i]);
    for (int i = nr - 1; i >= 1; i--) send_bit(1'b1, r[i]);
    f = {align_w(l, nl), align_w(r, nr)};
    if (pop_at_push) begin
      sck_i = 1'b0;
      ws_i = 1'b0;
      sd_i = r[0];
      repeat ($urandom_range(2, 3)) @(negedge clk_i);
      sck_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("full_head", frame_o, exp_q[0]);
      chk("full_level", level_o, DEP);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      @(negedge clk_i);
      void'(exp_q.pop_front());
      exp_q.push_back(f);
    end else begin
      send_bit(1'b0, r[0]);
      if (exp_q.size() < DEP) exp_q.push_back(f);
      else ovr_exp++;
    end
  endtask

  task automatic rand_frame(input bit pop_at_push);
    int nl, nr;
    logic [31:0] l, r;
    nl = $urandom_range(1, 24);
    nr = $urandom_range(1, 24);
    l = $urandom & ((32'h1 << nl) - 1);
    r = $urandom & ((32'h1 << nr) - 1);
    send_frame(l, nl, r, nr, pop_at_push);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_i);
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk("drain_level", level_o, exp_q.size());
      chk("drain_valid", valid_o, 1);
      chk("drain_frame", frame_o, exp_q[0]);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      void'(exp_q.pop_front());
    end
    chk("drain_empty", valid_o, 0);
    chk("drain_level0", level_o, 0);
  endtask

  initial begin
    logic [31:0] tmp;
    repeat (3) @(negedge clk_i);
    chk("rst_frame", frame_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovr", overrun_o, 0);
    rst_n = 1'b1;
    en_i = 1'b1;
    @(negedge clk_i);

    // Nominal 16-bit stereo frame.
    preamble();
    send_frame(32'hA5C3, 16, 32'h0F01, 16, 0);
    settle();
    chk("t1_frame", frame_o, 32'hA5C30F01);
    chk("t1_valid", valid_o, 1);
    chk("t1_level", level_o, 1);
    drain();

    // 24-bit words truncate, 8-bit words pad.
    tmp = $urandom & 32'hFFFFFF;
    send_frame(32'h123456, 24, tmp, 24, 0);
    settle();
    chk("t2_left24", frame_o[31:16], 16'h1234);
    drain();
    tmp = $urandom & 32'hFF;
    send_frame(32'hB7, 8, tmp, 8, 0);
    settle();
    chk("t3_left8", frame_o[31:16], 16'hB700);
    drain();

    // Five frames into a four-deep FIFO with the consumer stalled.
    for (int k = 0; k < 5; k++) rand_frame(0);
    settle();
    chk("t4_level", level_o, DEP);
    chk("t4_ovr", ovr_seen, 1);
    chk("t4_ovr_model", ovr_seen, ovr_exp);
    drain();

    // Full FIFO popped on the exact push cycle: nothing dropped.
    for (int k = 0; k < 4; k++) rand_frame(0);
    settle();
    rand_frame(1);
    settle();
    chk("t5_level", level_o, DEP);
    chk("t5_ovr", ovr_seen, ovr_exp);
    drain();

    // Disable mid-right-word flushes and forces a fresh alignment.
    rand_frame(0);
    for (int i = 15; i >= 1; i--) send_bit(1'b0, 1'($urandom));
    send_bit(1'b1, 1'($urandom));
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'($urandom));
    en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("t6_valid", valid_o, 0);
    chk("t6_level", level_o, 0);
    chk("t6_frame", frame_o, 0);
    exp_q.delete();
    en_i = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'($urandom));
    send_bit(1'b0, 1'($urandom));
    settle();
    chk("t6_nofr", level_o, 0);
    rand_frame(0);
    settle();
    drain();

    // Asynchronous reset in the middle of a left word.
    rand_frame(0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_frame", frame_o, 0);
    chk("t7_valid", valid_o, 0);
    chk("t7_level", level_o, 0);
    chk("t7_ovr", overrun_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    preamble();
    rand_frame(0);
    settle();
    drain();

    chk("ovr_total", ovr_seen, ovr_exp);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
